// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and default parameters for the register-file access arbiter.
//   state_t        : arbiter FSM states (IDLE / ISSUE / WAIT_RD)
//   *_DEF          : default WIDTH / ADDR / N_REQ / TIMEOUT values
//   to_cnt_w()     : width of a counter that must be able to hold TIMEOUT
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int ADDR_DEF    = 4;
  localparam int N_REQ_DEF   = 2;
  localparam int TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  // Timeout counter must represent 0..TIMEOUT inclusive.
  function automatic int to_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int TO_CNT_W_DEF = to_cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/rf_access_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The search starts at last_in+1 and
// wraps, so the most recent winner gets the lowest priority next time.
//   req_in      [N-1:0]  : pending requests
//   last_in     [IW-1:0] : index of the previous winner
//   onehot_out  [N-1:0]  : one-hot winner (all zero when nothing pending)
//   idx_out     [IW-1:0] : winner index (last_in when nothing pending)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_in,
  input  logic [IW-1:0] last_in,
  output logic [N-1:0]  onehot_out,
  output logic [IW-1:0] idx_out
);

  logic found_s;

  // Scan N positions starting after the previous winner; first hit wins.
  always_comb begin
    onehot_out = '0;
    idx_out    = last_in;
    found_s    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      int          cand;
      logic [IW-1:0] cand_idx;
      cand     = (int'(last_in) + i) % N;
      cand_idx = cand[IW-1:0];
      if (!found_s && req_in[cand_idx]) begin
        found_s              = 1'b1;
        onehot_out[cand_idx] = 1'b1;
        idx_out              = cand_idx;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter
// Round-robin arbiter sharing one register-file port between N_REQ
// requesters. Each transaction: grant + strobe for one cycle (ISSUE); reads
// then wait for rf_rd_data_valid_in or fail after TIMEOUT cycles.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req_in/req_wr_in         : per-requester request and write(1)/read(0)
//   req_addr_in/req_wr_data_in : packed per-requester address / write data
//   gnt_out                  : one-cycle one-hot grant
//   rd_data_out              : read data (shared), holds between completions
//   rd_data_valid_out/rd_err_out : one-cycle completion / timeout per owner
//   busy_out                 : state != IDLE
//   rf_*                     : register-file port
// All outputs except busy_out are registered.
// ---------------------------------------------------------------------------
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADDR    = ADDR_DEF,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ-1:0]       req_wr_in,
  input  logic [N_REQ*ADDR-1:0]  req_addr_in,
  input  logic [N_REQ*WIDTH-1:0] req_wr_data_in,
  output logic [N_REQ-1:0]       gnt_out,
  output logic [WIDTH-1:0]       rd_data_out,
  output logic [N_REQ-1:0]       rd_data_valid_out,
  output logic [N_REQ-1:0]       rd_err_out,
  output logic                   busy_out,
  output logic                   rf_wr_en_out,
  output logic                   rf_rd_en_out,
  output logic [ADDR-1:0]        rf_addr_out,
  output logic [WIDTH-1:0]       rf_wr_data_out,
  input  logic [WIDTH-1:0]       rf_rd_data_in,
  input  logic                   rf_rd_data_valid_in
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = to_cnt_w(TIMEOUT);

  state_t            state_q,   state_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [IW-1:0]     last_q,    last_d;
  logic [IW-1:0]     owner_q,   owner_d;
  logic              is_wr_q,   is_wr_d;
  logic [N_REQ-1:0]  gnt_q,     gnt_d;
  logic              wr_en_q,   wr_en_d;
  logic              rd_en_q,   rd_en_d;
  logic [ADDR-1:0]   addr_q,    addr_d;
  logic [WIDTH-1:0]  wdata_q,   wdata_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [N_REQ-1:0]  rd_vld_q,  rd_vld_d;
  logic [N_REQ-1:0]  rd_err_q,  rd_err_d;

  logic [N_REQ-1:0]  pick_oh_s;
  logic [IW-1:0]     pick_idx_s;
  logic [N_REQ-1:0]  owner_oh_s;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_in     (req_in),
    .last_in    (last_q),
    .onehot_out (pick_oh_s),
    .idx_out    (pick_idx_s)
  );

  assign owner_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  // State and output registers; synchronous reset drops any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IW'(N_REQ - 1);
      owner_q   <= '0;
      is_wr_q   <= 1'b0;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= '0;
      rd_err_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      is_wr_q   <= is_wr_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Next-state logic. Grant/strobe registers are loaded on the IDLE->ISSUE
  // edge so they are high exactly during the ISSUE cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    is_wr_d   = is_wr_q;
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = '0;
    rd_err_d  = '0;
    case (state_q)
      IDLE: begin
        if (|req_in) begin
          state_d = ISSUE;
          last_d  = pick_idx_s;
          owner_d = pick_idx_s;
          is_wr_d = req_wr_in[pick_idx_s];
          gnt_d   = pick_oh_s;
          wr_en_d = req_wr_in[pick_idx_s];
          rd_en_d = ~req_wr_in[pick_idx_s];
          addr_d  = req_addr_in[int'(pick_idx_s)*ADDR +: ADDR];
          wdata_d = req_wr_data_in[int'(pick_idx_s)*WIDTH +: WIDTH];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (is_wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RD;
          cnt_d   = '0;
        end
      end
      WAIT_RD: begin
        // A valid on the final counting cycle still wins over the timeout.
        if (rf_rd_data_valid_in) begin
          rd_data_d = rf_rd_data_in;
          rd_vld_d  = owner_oh_s;
          state_d   = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rd_data_d = '0;
          rd_vld_d  = owner_oh_s;
          rd_err_d  = owner_oh_s;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_out          = (state_q != IDLE);
  assign gnt_out           = gnt_q;
  assign rf_wr_en_out      = wr_en_q;
  assign rf_rd_en_out      = rd_en_q;
  assign rf_addr_out       = addr_q;
  assign rf_wr_data_out    = wdata_q;
  assign rd_data_out       = rd_data_q;
  assign rd_data_valid_out = rd_vld_q;
  assign rd_err_out        = rd_err_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_access_arbiter
// Directed stimulus pushes expected grant / read-completion events (with the
// cycle they must appear in) into a queue; an independent monitor pops and
// compares whenever the DUT shows a grant, strobe, valid or error.
// ---------------------------------------------------------------------------
module tb_rf_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_in, req_wr_in;
  logic [7:0]  req_addr_in;
  logic [15:0] req_wr_data_in;
  logic [1:0]  gnt_out, rd_data_valid_out, rd_err_out;
  logic [7:0]  rd_data_out, rf_wr_data_out, rf_rd_data_in;
  logic        busy_out, rf_wr_en_out, rf_rd_en_out, rf_rd_data_valid_in;
  logic [3:0]  rf_addr_out;

  // reg_file model: answers a read strobe one cycle later when enabled
  logic        mdl_on, mdl_pend, mdl_vld;
  logic [7:0]  mdl_value;
  logic        stray_vld;
  logic [7:0]  stray_data;

  assign rf_rd_data_valid_in = mdl_vld | stray_vld;
  assign rf_rd_data_in       = stray_vld ? stray_data : (mdl_vld ? mdl_value : 8'h00);

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    bit         is_rd;
    logic [1:0] who;
    logic [1:0] err;
    logic       we;
    logic       re;
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];

  rf_access_arbiter #(.WIDTH(8), .ADDR(4), .N_REQ(2), .TIMEOUT(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_in              (req_in),
    .req_wr_in           (req_wr_in),
    .req_addr_in         (req_addr_in),
    .req_wr_data_in      (req_wr_data_in),
    .gnt_out             (gnt_out),
    .rd_data_out         (rd_data_out),
    .rd_data_valid_out   (rd_data_valid_out),
    .rd_err_out          (rd_err_out),
    .busy_out            (busy_out),
    .rf_wr_en_out        (rf_wr_en_out),
    .rf_rd_en_out        (rf_rd_en_out),
    .rf_addr_out         (rf_addr_out),
    .rf_wr_data_out      (rf_wr_data_out),
    .rf_rd_data_in       (rf_rd_data_in),
    .rf_rd_data_valid_in (rf_rd_data_valid_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input int c, input logic [1:0] g, input logic we, input logic re,
                          input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.is_rd = 1'b0; e.who = g; e.err = 2'b00;
    e.we = we; e.re = re; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [1:0] v, input logic [1:0] er, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.is_rd = 1'b1; e.who = v; e.err = er;
    e.we = 1'b0; e.re = 1'b0; e.a = 4'h0; e.d = d;
    sb.push_back(e);
  endtask

  // reg_file read-response model
  initial begin
    mdl_pend = 1'b0;
    mdl_vld  = 1'b0;
    forever begin
      @(negedge clk);
      mdl_vld  = mdl_pend;
      mdl_pend = mdl_on && rf_rd_en_out;
    end
  end

  // Monitor: compares every visible DUT event against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((gnt_out != 2'b00) || (rd_data_valid_out != 2'b00) || (rd_err_out != 2'b00) ||
          rf_wr_en_out || rf_rd_en_out) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event cyc=%0d gnt=%b vld=%b err=%b we=%b re=%b want no event",
                   cyc, gnt_out, rd_data_valid_out, rd_err_out, rf_wr_en_out, rf_rd_en_out);
        end else begin
          e = sb.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          if (e.is_rd) begin
            check("rd_event", {rd_data_valid_out, rd_err_out, gnt_out, rf_wr_en_out, rf_rd_en_out, rd_data_out},
                  {e.who, e.err, 2'b00, 1'b0, 1'b0, e.d});
          end else begin
            check("gnt_event", {gnt_out, rd_data_valid_out, rd_err_out, rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out},
                  {e.who, 2'b00, 2'b00, e.we, e.re, e.a, e.d});
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total++; bad++;
        $display("FAIL missing_event got none want event at cyc=%0d who=%b", e.cyc, e.who);
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1; req_in = 2'b00; req_wr_in = 2'b00; req_addr_in = 8'h00; req_wr_data_in = 16'h0000;
    mdl_on = 1'b0; mdl_value = 8'h00; stray_vld = 1'b0; stray_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {gnt_out, rd_data_valid_out, rd_err_out, busy_out, rf_wr_en_out, rf_rd_en_out,
                            rf_addr_out, rf_wr_data_out, rd_data_out}, 64'h0);
    reset = 1'b0;

    // Contention: both hold writes, grants alternate starting with requester 0
    @(negedge clk); t = cyc;
    req_addr_in = {4'h6, 4'h5}; req_wr_data_in = {8'h61, 8'h50};
    push_gnt(t+1, 2'b01, 1'b1, 1'b0, 4'h5, 8'h50);
    push_gnt(t+3, 2'b10, 1'b1, 1'b0, 4'h6, 8'h61);
    push_gnt(t+5, 2'b01, 1'b1, 1'b0, 4'h5, 8'h50);
    push_gnt(t+7, 2'b10, 1'b1, 1'b0, 4'h6, 8'h61);
    req_wr_in = 2'b11; req_in = 2'b11;
    repeat (7) @(negedge clk);
    req_in = 2'b00;
    @(negedge clk);

    // Single write: req0 addr 3 data A5
    @(negedge clk); t = cyc;
    req_addr_in = {4'h0, 4'h3}; req_wr_data_in = {8'h00, 8'hA5}; req_wr_in = 2'b01;
    push_gnt(t+1, 2'b01, 1'b1, 1'b0, 4'h3, 8'hA5);
    req_in = 2'b01;
    @(negedge clk); req_in = 2'b00;
    check("wr_busy_issue", 64'(busy_out), 64'd1);
    @(negedge clk);
    check("wr_busy_done", 64'(busy_out), 64'd0);

    // Timeout: req0 reads addr 7, nobody answers; then req1 writes normally
    t = cyc; mdl_on = 1'b0;
    req_addr_in = {4'h9, 4'h7}; req_wr_data_in = {8'h99, 8'h00}; req_wr_in = 2'b10;
    push_gnt(t+1, 2'b01, 1'b0, 1'b1, 4'h7, 8'h00);
    push_rd(t+6, 2'b01, 2'b01, 8'h00);
    req_in = 2'b01;
    @(negedge clk); req_in = 2'b00;
    repeat (4) @(negedge clk);
    check("to_busy_wait", 64'(busy_out), 64'd1);
    @(negedge clk);
    push_gnt(t+7, 2'b10, 1'b1, 1'b0, 4'h9, 8'h99);
    req_in = 2'b10;
    @(negedge clk); req_in = 2'b00;
    @(negedge clk);

    // Single read: req1 addr 2, model returns 3C one cycle after rd_en
    t = cyc; mdl_on = 1'b1; mdl_value = 8'h3C;
    req_addr_in = {4'h2, 4'h0}; req_wr_data_in = {8'h11, 8'h00}; req_wr_in = 2'b00;
    push_gnt(t+1, 2'b10, 1'b0, 1'b1, 4'h2, 8'h11);
    push_rd(t+3, 2'b10, 2'b00, 8'h3C);
    req_in = 2'b10;
    @(negedge clk); req_in = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rd_busy_done", 64'(busy_out), 64'd0);
    mdl_on = 1'b0;
    @(negedge clk);

    // Stray valid in IDLE must be ignored
    stray_data = 8'hFF; stray_vld = 1'b1;
    @(negedge clk); stray_vld = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_rd_data_hold", 64'(rd_data_out), 64'h3C);
    check("stray_busy", 64'(busy_out), 64'd0);

    // Reset while in WAIT_RD, valid arrives the cycle after
    t = cyc;
    req_addr_in = {4'h0, 4'h1}; req_wr_data_in = 16'h0000; req_wr_in = 2'b00;
    push_gnt(t+1, 2'b01, 1'b0, 1'b1, 4'h1, 8'h00);
    req_in = 2'b01;
    @(negedge clk); req_in = 2'b00;
    @(negedge clk);
    check("midrd_busy_wait", 64'(busy_out), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stray_data = 8'h77; stray_vld = 1'b1;
    check("midrd_reset_outs", {gnt_out, rd_data_valid_out, rd_err_out, busy_out, rf_wr_en_out, rf_rd_en_out,
                               rf_addr_out, rf_wr_data_out, rd_data_out}, 64'h0);
    @(negedge clk); stray_vld = 1'b0;
    @(negedge clk);
    check("midrd_after_outs", {gnt_out, rd_data_valid_out, rd_err_out, busy_out, rd_data_out}, 64'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
